// File: rtl/pmu_serial_feeder.sv
// pmu_serial_feeder: converts host word packets (header + payload) into the PMU's stall-free serial stream.
// Optional opcode whitelist on headers is enabled by defining PMU_FEEDER_OPCODE_CHECK_EN.
module pmu_serial_feeder #(
    parameter int WORD_WIDTH   = 32,
    parameter int HEADER_WIDTH = 32,
    parameter int DRAIN_CYCLES = 160,
    parameter int LEN_MAX      = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [WORD_WIDTH-1:0] s_data,
    input  logic                  s_last,
    input  logic                  pwr_up_req,
    output logic                  en,
    output logic                  data_o,
    output logic                  pwr_up_en,
    output logic                  busy,
    output logic [1:0]            err_o,
    output logic [2:0]            o_dbg_state
);

    localparam int CNT_W  = 28;
    localparam int WPOS_W = $clog2(WORD_WIDTH);
    localparam logic [CNT_W-1:0]  HDR_LAST   = CNT_W'(HEADER_WIDTH - 1);
    localparam logic [CNT_W-1:0]  DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0]  LEN_LIMIT  = CNT_W'(LEN_MAX);
    localparam logic [WPOS_W-1:0] WPOS_LAST  = WPOS_W'(WORD_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        HDR   = 3'd2,
        PAY   = 3'd3,
        DRAIN = 3'd4,
        PWRUP = 3'd5,
        FLUSH = 3'd6
    } state_t;

    state_t                r_state;
    logic                  r_init;
    logic                  r_en;
    logic                  r_data_o;
    logic                  r_pwr_up_en;
    logic                  r_busy;
    logic [1:0]            r_err;
    logic                  r_pwr_pend;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      r_len;
    logic [CNT_W-1:0]      r_words_left;
    logic [WPOS_W-1:0]     r_wpos;
    logic [HEADER_WIDTH-1:0] r_hdr_sh;
    logic [WORD_WIDTH-1:0] r_shift;
    logic [WORD_WIDTH-1:0] r_buf;
    logic                  r_buf_vld;
    logic                  r_got_last;
    logic                  r_zero;

    logic                  w_s_ready;
    logic                  w_hs;
    logic                  w_fetch;
    logic                  w_boundary;
    logic                  w_src_vld;
    logic [WORD_WIDTH-1:0] w_src;
    logic [CNT_W-1:0]      w_hdr_len;
    logic [CNT_W-1:0]      w_hdr_words;
    logic                  w_op_bad;
    logic                  w_hdr_bad;
    logic                  w_ld_bit;
    logic [WORD_WIDTH-1:0] w_ld_shift;
    logic                  w_ld_zero;
    logic                  w_ld_under;

    // Stream handshake: a word transfers on a rising edge where s_valid and s_ready are both high;
    // s_ready depends only on registered state, never on s_valid.
    always_comb begin
        w_s_ready = 1'b0;
        case (r_state)
            IDLE:            w_s_ready = r_init;
            START, HDR, PAY: w_s_ready = !r_buf_vld && (r_words_left != '0) && !r_got_last && !r_zero;
            FLUSH:           w_s_ready = 1'b1;
            default:         w_s_ready = 1'b0;
        endcase
    end

    assign w_hs    = s_valid && w_s_ready;
    assign w_fetch = w_hs && ((r_state == START) || (r_state == HDR) || (r_state == PAY));

    assign w_hdr_len   = s_data[WORD_WIDTH-1:4];
    assign w_hdr_words = {5'd0, w_hdr_len[CNT_W-1:5]} + {{(CNT_W-1){1'b0}}, |w_hdr_len[4:0]};

`ifdef PMU_FEEDER_OPCODE_CHECK_EN
    logic [3:0] w_hdr_op;
    assign w_hdr_op = s_data[3:0];
    assign w_op_bad = !((w_hdr_op == 4'b1010) || (w_hdr_op == 4'b0001) || (w_hdr_op == 4'b0010));
`else
    assign w_op_bad = 1'b0;
`endif

    // A single-word header packet is malformed whatever its length says.
    assign w_hdr_bad = s_last || (w_hdr_len == '0) || (w_hdr_len > LEN_LIMIT) || w_op_bad;

    // A word boundary is the edge that loads bit 0 of the next payload word.
    assign w_boundary = ((r_state == HDR) && (r_cnt == HDR_LAST)) ||
                        ((r_state == PAY) && (r_cnt != CNT_W'(1)) && (r_wpos == WPOS_LAST));

    // An empty buffer at the boundary may be bypassed by a word arriving on that same edge.
    assign w_src_vld = r_buf_vld || w_fetch;
    assign w_src     = r_buf_vld ? r_buf : s_data;

    always_comb begin
        w_ld_bit   = 1'b0;
        w_ld_shift = '0;
        w_ld_zero  = r_zero;
        w_ld_under = 1'b0;
        if (r_zero) begin
            w_ld_zero = 1'b1;
        end else if (w_src_vld) begin
            w_ld_bit   = w_src[0];
            w_ld_shift = w_src >> 1;
        end else if (r_got_last) begin
            w_ld_zero = 1'b1;
        end else begin
            w_ld_zero  = 1'b1;
            w_ld_under = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_init       <= 1'b0;
            r_en         <= 1'b0;
            r_data_o     <= 1'b0;
            r_pwr_up_en  <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= 2'd0;
            r_pwr_pend   <= 1'b0;
            r_cnt        <= '0;
            r_len        <= '0;
            r_words_left <= '0;
            r_wpos       <= '0;
            r_hdr_sh     <= '0;
            r_shift      <= '0;
            r_buf        <= '0;
            r_buf_vld    <= 1'b0;
            r_got_last   <= 1'b0;
            r_zero       <= 1'b0;
        end else begin
            r_init      <= 1'b1;
            r_en        <= 1'b0;
            r_pwr_up_en <= 1'b0;

            if (w_fetch) begin
                r_words_left <= r_words_left - CNT_W'(1);
                if (s_last) begin
                    r_got_last <= 1'b1;
                    if (r_words_left != CNT_W'(1)) begin
                        r_err <= 2'd2;
                    end
                end
                if (!w_boundary) begin
                    r_buf     <= s_data;
                    r_buf_vld <= 1'b1;
                end
            end
            if (w_boundary) begin
                r_buf_vld <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    r_data_o <= 1'b0;
                    if (w_hs) begin
                        r_hdr_sh     <= s_data;
                        r_len        <= w_hdr_len;
                        r_words_left <= w_hdr_words;
                        r_got_last   <= 1'b0;
                        r_zero       <= 1'b0;
                        r_buf_vld    <= 1'b0;
                        if (pwr_up_req) begin
                            r_pwr_pend <= 1'b1;
                        end
                        if (w_hdr_bad) begin
                            r_err <= 2'd3;
                            if (!s_last) begin
                                r_state <= FLUSH;
                                r_busy  <= 1'b1;
                            end
                        end else begin
                            r_err   <= 2'd0;
                            r_state <= START;
                            r_en    <= 1'b1;
                            r_busy  <= 1'b1;
                        end
                    end else if (pwr_up_req || r_pwr_pend) begin
                        r_pwr_pend  <= 1'b0;
                        r_state     <= PWRUP;
                        r_pwr_up_en <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                START: begin
                    r_data_o <= r_hdr_sh[0];
                    r_hdr_sh <= r_hdr_sh >> 1;
                    r_cnt    <= '0;
                    r_state  <= HDR;
                end
                HDR: begin
                    if (r_cnt == HDR_LAST) begin
                        r_state  <= PAY;
                        r_cnt    <= r_len;
                        r_wpos   <= '0;
                        r_data_o <= w_ld_bit;
                        r_shift  <= w_ld_shift;
                        r_zero   <= w_ld_zero;
                        if (w_ld_under) begin
                            r_err <= 2'd1;
                        end
                    end else begin
                        r_cnt    <= r_cnt + CNT_W'(1);
                        r_data_o <= r_hdr_sh[0];
                        r_hdr_sh <= r_hdr_sh >> 1;
                    end
                end
                PAY: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_data_o <= 1'b0;
                        // Only a properly terminated packet skips the flush of trailing host words.
                        if (r_got_last) begin
                            r_state <= DRAIN;
                            r_cnt   <= DRAIN_LOAD;
                        end else begin
                            r_state <= FLUSH;
                        end
                    end else begin
                        r_cnt  <= r_cnt - CNT_W'(1);
                        r_wpos <= r_wpos + WPOS_W'(1);
                        if (r_wpos == WPOS_LAST) begin
                            r_data_o <= w_ld_bit;
                            r_shift  <= w_ld_shift;
                            r_zero   <= w_ld_zero;
                            if (w_ld_under) begin
                                r_err <= 2'd1;
                            end
                        end else begin
                            r_data_o <= r_zero ? 1'b0 : r_shift[0];
                            r_shift  <= r_shift >> 1;
                        end
                    end
                end
                DRAIN: begin
                    r_data_o <= 1'b0;
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                PWRUP: begin
                    r_state <= DRAIN;
                    r_cnt   <= DRAIN_LOAD;
                end
                FLUSH: begin
                    r_data_o <= 1'b0;
                    if (w_hs && s_last) begin
                        r_state <= DRAIN;
                        r_cnt   <= DRAIN_LOAD;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready     = w_s_ready;
    assign en          = r_en;
    assign data_o      = r_data_o;
    assign pwr_up_en   = r_pwr_up_en;
    assign busy        = r_busy;
    assign err_o       = r_err;
    assign o_dbg_state = r_state;

endmodule

// File: doc/pmu_serial_feeder.md
Name: pmu_serial_feeder

Overview:
- Upstream stage of the PMU: takes word-wide bitstream packets from the host/JTAG side over a valid/ready stream and turns them into the PMU's serial interface (en, data_i, pwr_up_en).
- Each packet is one header word followed by ceil(L/WORD_WIDTH) payload words. L = header[31:4], opcode = header[3:0].
- Output is strictly bit-per-cycle with no stalls, because the PMU counts cycles and cannot be back-pressured.

Parameters:
- WORD_WIDTH, 32, host stream word width; fixed equal to HEADER_WIDTH.
- HEADER_WIDTH, 32, header length in bits, serialized LSB first.
- DRAIN_CYCLES, 160, idle cycles after the last payload bit (or after a power-up pulse) so the PMU can return to idle; must be >= AES latency + AES block width + 2.
- LEN_MAX, 4096, largest accepted L in bits.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  host word valid
- s_ready  out  1  feeder accepts word when s_valid & s_ready
- s_data  in  WORD_WIDTH  host word
- s_last  in  1  marks final word of packet
- pwr_up_req  in  1  request a memory-to-scan-chain boot replay
- en  out  1  one-cycle start pulse to the PMU
- data_o  out  1  serial bit to the PMU data_i
- pwr_up_en  out  1  one-cycle power-up pulse to the PMU
- busy  out  1  high in every state except IDLE
- err_o  out  2  sticky error code: 0 none, 1 underrun, 2 early s_last, 3 bad header; cleared on next accepted header

Behaviour:
- Reset (async assert, sync deassert): state=IDLE; s_ready=0 for the first cycle after deassert, then 1; en=0, data_o=0, pwr_up_en=0, busy=0, err_o=0; word buffer empty.
- States: IDLE, START, HDR, PAY, DRAIN, PWRUP, FLUSH.
- IDLE:
  - s_ready=1.
  - On a handshake the header is latched. If s_last=1 and L!=0, or L=0, or L>LEN_MAX: err_o=3, go to FLUSH (or back to IDLE if s_last=1). Otherwise go to START.
  - pwr_up_req with no simultaneous handshake: go to PWRUP. A simultaneous handshake wins; the request stays pending (level-sampled) until IDLE is re-entered.
- START: en=1 for exactly one cycle, data_o=0, s_ready=1 to prefetch payload word 0. Next state HDR.
- HDR:
  - HEADER_WIDTH cycles; data_o=header[k] on cycle k (k=0..31). en=0.
  - s_ready=1 while the one-word payload buffer is empty.
- PAY:
  - L cycles; data_o = bit (i mod WORD_WIDTH) of the current word, LSB first.
  - At a word boundary the buffered word moves to the shift register in the same cycle with no bubble. s_ready=1 while the buffer is empty and words remain.
  - Words remaining = ceil(L/WORD_WIDTH) minus words accepted. Bits of the final word beyond L are discarded.
- Underrun: at a word boundary with the buffer empty, err_o=1, data_o=0 for the rest of the packet length (the length is still honoured so the PMU counter stays aligned), then FLUSH.
- s_last on a word that is not the final expected word: err_o=2. That word is still serialized, remaining bits are zero-filled, then DRAIN.
- Final expected word without s_last: go to FLUSH after the PAY bits.
- DRAIN: DRAIN_CYCLES cycles, s_ready=0, data_o=0, then IDLE.
- PWRUP: pwr_up_en=1 for one cycle, then DRAIN.
- FLUSH: s_ready=1; discard words until a handshake with s_last=1, then DRAIN.
- A packet in flight is never aborted except by rst_n. Reset mid-packet returns to IDLE immediately and drops all buffered data.
- Length counter is 28 bits; L=LEN_MAX is legal.

Optional Feature:
- Macro: PMU_FEEDER_OPCODE_CHECK_EN.
- Defined: the header opcode must be 4'b1010, 4'b0001 or 4'b0010. Any other opcode gives err_o=3 and FLUSH, with no en pulse.
- Undefined: all opcodes are forwarded unchecked.

Test Plan:
- Header 0x0000_080A (L=128, op 1010) plus 4 words, last flagged -> en pulse 1 cycle, 32 header bits LSB first, then 128 payload bits contiguous, then 160 drain cycles; busy low after; err_o=0.
- Header L=40 (0x0000_0281) plus 2 words -> 40 payload bits; upper 24 bits of word 1 never appear on data_o.
- L=128, host withholds word 2 -> err_o=1, data_o=0 for the remaining 64 bits, FLUSH until s_last.
- L=128, s_last on word 1 -> err_o=2, 64 data bits plus 64 zero bits, DRAIN, IDLE.
- pwr_up_req=1 in IDLE -> pwr_up_en high exactly 1 cycle, busy for 1+160 cycles; pwr_up_req together with a header handshake -> packet runs first, then the pwr_up_en pulse.
- rst_n low mid-PAY -> all outputs 0 asynchronously; with the macro defined, opcode 4'b0111 -> err_o=3, no en.
